bufr_align_ctrl: RTL and testbench
==================================

BUFR_ALIGN_CTRL -- requirements
Module: bufr_align_ctrl

Interface
REQ-001 Parameter PORTS_ADC, default 8: number of ADC clock ports sequenced.
REQ-002 Parameter CLR_CYCLES, default 16: cycles BUFR_CLR_O is held high per attempt.
REQ-003 Parameter CE_WAIT_CYCLES, default 16: cycles between CLR release and CE assertion.
REQ-004 Parameter SETTLE_CYCLES, default 8: cycles after CE assertion before checking; covers the 3-FF synchronizer.
REQ-005 Parameter CHECK_CYCLES, default 64: length of the phase-compare window.
REQ-006 Parameter MISMATCH_TOL, default 4: maximum mismatch cycles allowed in one window.
REQ-007 Parameter MAX_RETRY, default 4: total attempts, range 1..15.
REQ-008 CLK_I  in  1  system/debug clock; all logic is on this clock.
REQ-009 RST_I  in  1  asynchronous, active-high reset.
REQ-010 START_I  in  1  single-cycle request to start an alignment sequence.
REQ-011 BUFR_CLK_SYNC_I  in  PORTS_ADC  divided BUFR clocks, already synchronized to CLK_I.
REQ-012 BUFR_CE_O  out  PORTS_ADC  per-port BUFR CE; drives the clock buffer CE inputs.
REQ-013 BUFR_CLR_O  out  1  common BUFR asynchronous clear.
REQ-014 BUSY_O  out  1  high from the cycle after an accepted START until DONE or FAIL.
REQ-015 DONE_O  out  1  level; alignment passed.
REQ-016 FAIL_O  out  1  level; all attempts exhausted.
REQ-017 RETRY_CNT_O  out  4  index of the current or last attempt, 0-based.

Function
REQ-018 All outputs SHALL be registered, with no combinational path from input to output.
REQ-019 FSM states SHALL be IDLE, CLEAR, WAIT_CE, ENABLE, SETTLE, CHECK, DONE, FAIL.
REQ-020 IDLE/DONE/FAIL SHALL accept START_I; it is ignored in all other states.
REQ-021 Accepted START SHALL clear DONE_O/FAIL_O, zero RETRY_CNT_O and enter CLEAR, with BUSY_O=1, on the next cycle.
REQ-022 CLEAR: BUFR_CLR_O=1, BUFR_CE_O=0 for exactly CLR_CYCLES cycles, then go to WAIT_CE.
REQ-023 WAIT_CE: BUFR_CLR_O=0, BUFR_CE_O=0 for exactly CE_WAIT_CYCLES cycles, then go to ENABLE.
REQ-024 ENABLE (1 cycle): all BUFR_CE_O bits SHALL go high in the same register update and stay high through SETTLE, CHECK and DONE.
REQ-025 SETTLE SHALL wait SETTLE_CYCLES cycles, then enter CHECK, clearing the mismatch counter and the toggle flag.
REQ-026 CHECK, each cycle: mismatch when BUFR_CLK_SYNC_I is not all-0 and not all-1; the mismatch counter saturates at its max.
REQ-027 CHECK: toggle flag SHALL set when bit 0 differs from its value on the previous cycle.
REQ-028 End of window (CHECK_CYCLES cycles) passes if mismatch count <= MISMATCH_TOL and the toggle flag is set.
REQ-029 Pass SHALL enter DONE: DONE_O=1, BUSY_O=0, CE all 1, CLR 0, RETRY_CNT_O holds the passing attempt index.
REQ-030 On a failing attempt with RETRY_CNT_O < MAX_RETRY-1, increment RETRY_CNT_O and re-enter CLEAR.
REQ-031 On a failing attempt with RETRY_CNT_O = MAX_RETRY-1, enter FAIL: FAIL_O=1, BUSY_O=0, CE all 0, CLR 1.
REQ-032 No clock (toggle flag clear) SHALL count as a failing attempt.
REQ-033 DONE_O and FAIL_O SHALL never be high simultaneously.
REQ-034 A single down-counter sized for the largest of the delay parameters SHALL serve all timed states.

Reset
REQ-035 While RST_I is high: state IDLE, BUFR_CE_O=0, BUFR_CLR_O=1, BUSY_O=0, DONE_O=0, FAIL_O=0, RETRY_CNT_O=0, all counters 0.
REQ-036 Reset mid-sequence SHALL abort immediately to the reset values; no auto-restart after reset.
REQ-037 After reset, outputs SHALL hold reset values in IDLE until START_I.

Verification
REQ-038 Scenario: reset, START; inputs are in-phase divide-by-4 clocks, identical on all bits. Required: CLR high 16 cycles, low 16 cycles, CE=0xFF, DONE_O=1 at START+~106 cycles, RETRY_CNT_O=0.
REQ-039 Scenario: bit 3 inverted relative to the others for all attempts. Required: 4 attempts, then FAIL_O=1, CE=0x00, CLR=1, RETRY_CNT_O=3.
REQ-040 Scenario: bit 5 out of phase in attempt 0 only. Required: retry once, then DONE_O=1, RETRY_CNT_O=1.
REQ-041 Scenario: BUFR_CLK_SYNC_I constant 0x00. Required: each attempt fails for no toggle, then FAIL_O=1.
REQ-042 Scenario: 3 injected mismatch cycles in the window. Required: pass; with 5 injected, the attempt fails.
REQ-043 Scenario: START during CHECK is ignored. Required: RST_I pulsed during WAIT_CE returns outputs to reset values within the same cycle; a new START then restarts from CLEAR.

Source files
------------

// File: rtl/bufr_align_ctrl.sv
// BUFR divided-clock alignment sequencer: clears all BUFRs, re-enables their CE
// together, then checks that the divided clocks come up in phase, retrying on failure.
`timescale 1ns/1ps

module bufr_align_ctrl #(
    parameter int PORTS_ADC      = 8,
    parameter int CLR_CYCLES     = 16,
    parameter int CE_WAIT_CYCLES = 16,
    parameter int SETTLE_CYCLES  = 8,
    parameter int CHECK_CYCLES   = 64,
    parameter int MISMATCH_TOL   = 4,
    parameter int MAX_RETRY      = 4
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 START_I,
    input  logic [PORTS_ADC-1:0] BUFR_CLK_SYNC_I,
    output logic [PORTS_ADC-1:0] BUFR_CE_O,
    output logic                 BUFR_CLR_O,
    output logic                 BUSY_O,
    output logic                 DONE_O,
    output logic                 FAIL_O,
    output logic [3:0]           RETRY_CNT_O
);

    localparam int MAX_A   = (CLR_CYCLES > CE_WAIT_CYCLES) ? CLR_CYCLES : CE_WAIT_CYCLES;
    localparam int MAX_B   = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int MAX_DLY = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int DLY_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
    localparam int MIS_W   = $clog2(CHECK_CYCLES + 1);

    localparam logic [DLY_W-1:0] CLR_LOAD    = DLY_W'(CLR_CYCLES - 1);
    localparam logic [DLY_W-1:0] CE_LOAD     = DLY_W'(CE_WAIT_CYCLES - 1);
    localparam logic [DLY_W-1:0] SETTLE_LOAD = DLY_W'(SETTLE_CYCLES - 1);
    localparam logic [DLY_W-1:0] CHECK_LOAD  = DLY_W'(CHECK_CYCLES - 1);
    localparam logic [MIS_W-1:0] MIS_MAX     = '1;
    localparam logic [3:0]       LAST_RETRY  = 4'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_CE,
        ST_ENABLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t           state;
    logic [DLY_W-1:0] dly_cnt;
    logic [MIS_W-1:0] mis_cnt;
    logic             tog_flag;
    logic             prev_bit0;

    logic             sample_mis;
    logic [MIS_W-1:0] mis_next;
    logic             tog_next;
    logic             window_pass;
    logic             start_ok;
    logic             cnt_zero;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sample_mis  = 1'b0;
        mis_next    = mis_cnt;
        tog_next    = tog_flag;
        window_pass = 1'b0;
        start_ok    = 1'b0;
        cnt_zero    = (dly_cnt == '0);

        // Ports disagree unless every divided clock shows the same level.
        sample_mis = !((BUFR_CLK_SYNC_I == '0) || (BUFR_CLK_SYNC_I == '1));
        if (sample_mis && (mis_cnt != MIS_MAX))
            mis_next = mis_cnt + 1'b1;
        tog_next    = tog_flag | (BUFR_CLK_SYNC_I[0] ^ prev_bit0);
        window_pass = (int'(mis_next) <= MISMATCH_TOL) && tog_next;
        start_ok    = START_I && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values and ordering inside the block does not matter.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state       <= ST_IDLE;
            dly_cnt     <= '0;
            mis_cnt     <= '0;
            tog_flag    <= 1'b0;
            prev_bit0   <= 1'b0;
            BUFR_CE_O   <= '0;
            BUFR_CLR_O  <= 1'b1;
            BUSY_O      <= 1'b0;
            DONE_O      <= 1'b0;
            FAIL_O      <= 1'b0;
            RETRY_CNT_O <= '0;
        end else begin
            prev_bit0 <= BUFR_CLK_SYNC_I[0];
            if (start_ok) begin
                state       <= ST_CLEAR;
                dly_cnt     <= CLR_LOAD;
                BUFR_CE_O   <= '0;
                BUFR_CLR_O  <= 1'b1;
                BUSY_O      <= 1'b1;
                DONE_O      <= 1'b0;
                FAIL_O      <= 1'b0;
                RETRY_CNT_O <= '0;
            end else begin
                case (state)
                    ST_CLEAR: begin
                        if (cnt_zero) begin
                            state      <= ST_WAIT_CE;
                            dly_cnt    <= CE_LOAD;
                            BUFR_CLR_O <= 1'b0;
                        end else begin
                            dly_cnt <= dly_cnt - 1'b1;
                        end
                    end
                    ST_WAIT_CE: begin
                        if (cnt_zero) begin
                            state     <= ST_ENABLE;
                            BUFR_CE_O <= '1;
                        end else begin
                            dly_cnt <= dly_cnt - 1'b1;
                        end
                    end
                    ST_ENABLE: begin
                        state   <= ST_SETTLE;
                        dly_cnt <= SETTLE_LOAD;
                    end
                    ST_SETTLE: begin
                        if (cnt_zero) begin
                            state    <= ST_CHECK;
                            dly_cnt  <= CHECK_LOAD;
                            mis_cnt  <= '0;
                            tog_flag <= 1'b0;
                        end else begin
                            dly_cnt <= dly_cnt - 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        mis_cnt  <= mis_next;
                        tog_flag <= tog_next;
                        if (!cnt_zero) begin
                            dly_cnt <= dly_cnt - 1'b1;
                        end else if (window_pass) begin
                            state  <= ST_DONE;
                            BUSY_O <= 1'b0;
                            DONE_O <= 1'b1;
                        end else if (RETRY_CNT_O == LAST_RETRY) begin
                            state      <= ST_FAIL;
                            BUSY_O     <= 1'b0;
                            FAIL_O     <= 1'b1;
                            BUFR_CE_O  <= '0;
                            BUFR_CLR_O <= 1'b1;
                        end else begin
                            state       <= ST_CLEAR;
                            dly_cnt     <= CLR_LOAD;
                            RETRY_CNT_O <= RETRY_CNT_O + 4'd1;
                            BUFR_CE_O   <= '0;
                            BUFR_CLR_O  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bufr_align_ctrl.sv
// Directed bench for bufr_align_ctrl: a table of input scenarios plus hand-written
// sequences for START-while-busy and mid-sequence reset.
`timescale 1ns/1ps

module tb_bufr_align_ctrl;

    localparam int ATTEMPT_LEN = 16 + 16 + 1 + 8 + 64;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic       START_I = 1'b0;
    logic [7:0] BUFR_CLK_SYNC_I = 8'h00;
    logic [7:0] BUFR_CE_O;
    logic       BUFR_CLR_O;
    logic       BUSY_O;
    logic       DONE_O;
    logic       FAIL_O;
    logic [3:0] RETRY_CNT_O;

    bufr_align_ctrl dut (
        .CLK_I           (CLK_I),
        .RST_I           (RST_I),
        .START_I         (START_I),
        .BUFR_CLK_SYNC_I (BUFR_CLK_SYNC_I),
        .BUFR_CE_O       (BUFR_CE_O),
        .BUFR_CLR_O      (BUFR_CLR_O),
        .BUSY_O          (BUSY_O),
        .DONE_O          (DONE_O),
        .FAIL_O          (FAIL_O),
        .RETRY_CNT_O     (RETRY_CNT_O)
    );

    always #5 CLK_I = ~CLK_I;

    int tests = 0;
    int failed = 0;
    int mode = 0;
    int inj_n = 0;
    int phase = 0;
    int ce_cnt = 0;
    int both_high = 0;

    typedef struct {
        int         mode;
        int         inj;
        logic       exp_done;
        logic       exp_fail;
        int         exp_retry;
        logic [7:0] exp_ce;
        logic       exp_clr;
    } vec_t;

    vec_t vecs [7];

    // Divide-by-4 reference clock on every bit, distorted according to mode.
    always @(negedge CLK_I) begin : stim
        logic [7:0] v;
        phase = phase + 1;
        v = phase[1] ? 8'hFF : 8'h00;
        if (BUFR_CE_O == 8'hFF && BUSY_O) ce_cnt = ce_cnt + 1;
        else ce_cnt = 0;
        if (DONE_O && FAIL_O) both_high = both_high + 1;
        case (mode)
            1: v[3] = ~v[3];
            2: if (RETRY_CNT_O == 4'd0) v[5] = ~v[5];
            3: v = 8'h00;
            4: if (RETRY_CNT_O == 4'd0 && ce_cnt >= 20 && ce_cnt < 20 + inj_n) v[2] = ~v[2];
            default: ;
        endcase
        BUFR_CLK_SYNC_I = v;
    end

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_ce"},    32'(BUFR_CE_O),   0);
        check({tag, "_clr"},   32'(BUFR_CLR_O),  1);
        check({tag, "_busy"},  32'(BUSY_O),      0);
        check({tag, "_done"},  32'(DONE_O),      0);
        check({tag, "_fail"},  32'(FAIL_O),      0);
        check({tag, "_retry"}, 32'(RETRY_CNT_O), 0);
    endtask

    task automatic do_start();
        @(negedge CLK_I);
        START_I = 1'b1;
        @(negedge CLK_I);
        START_I = 1'b0;
    endtask

    task automatic wait_end(input int poke_at, output int n, output int clr_hi, output int wait_lo);
        n = 0;
        clr_hi = 0;
        wait_lo = 0;
        while (BUSY_O && n < 2000) begin
            if (n < 32) begin
                if (BUFR_CLR_O && BUFR_CE_O == 8'h00) clr_hi = clr_hi + 1;
                if (!BUFR_CLR_O && BUFR_CE_O == 8'h00) wait_lo = wait_lo + 1;
            end
            @(negedge CLK_I);
            n = n + 1;
            START_I = (n == poke_at);
        end
        START_I = 1'b0;
        if (n >= 2000) check("busy_timeout", n, 0);
    endtask

    initial begin
        int n, clr_hi, wait_lo;

        vecs[0] = '{0, 0, 1'b1, 1'b0, 0, 8'hFF, 1'b0};
        vecs[1] = '{1, 0, 1'b0, 1'b1, 3, 8'h00, 1'b1};
        vecs[2] = '{2, 0, 1'b1, 1'b0, 1, 8'hFF, 1'b0};
        vecs[3] = '{3, 0, 1'b0, 1'b1, 3, 8'h00, 1'b1};
        vecs[4] = '{4, 3, 1'b1, 1'b0, 0, 8'hFF, 1'b0};
        vecs[5] = '{4, 4, 1'b1, 1'b0, 0, 8'hFF, 1'b0};
        vecs[6] = '{4, 5, 1'b1, 1'b0, 1, 8'hFF, 1'b0};

        repeat (3) @(negedge CLK_I);
        check_idle_reset("in_reset");
        RST_I = 1'b0;
        repeat (5) @(negedge CLK_I);
        check_idle_reset("post_reset");

        foreach (vecs[i]) begin
            mode  = vecs[i].mode;
            inj_n = vecs[i].inj;
            do_start();
            check($sformatf("v%0d_start_busy", i),  32'(BUSY_O),      1);
            check($sformatf("v%0d_start_clr", i),   32'(BUFR_CLR_O),  1);
            check($sformatf("v%0d_start_done", i),  32'(DONE_O),      0);
            check($sformatf("v%0d_start_fail", i),  32'(FAIL_O),      0);
            check($sformatf("v%0d_start_retry", i), 32'(RETRY_CNT_O), 0);
            wait_end(-1, n, clr_hi, wait_lo);
            check($sformatf("v%0d_clr_cycles", i),  clr_hi, 16);
            check($sformatf("v%0d_wait_cycles", i), wait_lo, 16);
            check($sformatf("v%0d_latency", i),     n, ATTEMPT_LEN * (vecs[i].exp_retry + 1));
            check($sformatf("v%0d_done", i),        32'(DONE_O),      32'(vecs[i].exp_done));
            check($sformatf("v%0d_fail", i),        32'(FAIL_O),      32'(vecs[i].exp_fail));
            check($sformatf("v%0d_retry", i),       32'(RETRY_CNT_O), vecs[i].exp_retry);
            check($sformatf("v%0d_ce", i),          32'(BUFR_CE_O),   32'(vecs[i].exp_ce));
            check($sformatf("v%0d_clr", i),         32'(BUFR_CLR_O),  32'(vecs[i].exp_clr));
        end

        // START pulsed in the middle of the check window must not restart.
        mode = 0;
        do_start();
        wait_end(60, n, clr_hi, wait_lo);
        check("ign_start_latency", n, ATTEMPT_LEN);
        check("ign_start_done",    32'(DONE_O), 1);
        check("ign_start_retry",   32'(RETRY_CNT_O), 0);
        repeat (5) @(negedge CLK_I);
        check("done_hold",    32'(DONE_O), 1);
        check("done_hold_ce", 32'(BUFR_CE_O), 32'hFF);

        // Reset asserted during WAIT_CE aborts without waiting for a clock edge.
        do_start();
        repeat (20) @(negedge CLK_I);
        check("wait_ce_clr",  32'(BUFR_CLR_O), 0);
        check("wait_ce_busy", 32'(BUSY_O), 1);
        #2 RST_I = 1'b1;
        #1 check_idle_reset("async_rst");
        @(negedge CLK_I);
        RST_I = 1'b0;
        repeat (10) @(negedge CLK_I);
        check_idle_reset("no_restart");
        do_start();
        check("restart_busy", 32'(BUSY_O), 1);
        check("restart_clr",  32'(BUFR_CLR_O), 1);
        wait_end(-1, n, clr_hi, wait_lo);
        check("restart_latency", n, ATTEMPT_LEN);
        check("restart_done",    32'(DONE_O), 1);

        check("done_fail_exclusive", both_high, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
